// File: rtl/deserializer_top.sv
// Serial-to-parallel receiver: MSB-first bits are packed into words, and each word is emitted with a bit-count code.
// Latency: the valid pulse rises on the edge that samples the last bit or the first idle cycle. No backpressure: a word is emitted whether or not the consumer is ready.
module deserializer_top #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [DATA_MOD_WIDTH:0]   LAST_CNT = (DATA_MOD_WIDTH+1)'(DATA_BUS_WIDTH - 1);
    localparam logic [DATA_MOD_WIDTH-1:0] TOP_POS  = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);

    state_t                    state, state_n;
    logic [DATA_BUS_WIDTH-1:0] sh, sh_n;
    logic [DATA_MOD_WIDTH:0]   cnt, cnt_n;
    logic [DATA_MOD_WIDTH-1:0] pos;
    logic                      emit;
    logic [DATA_BUS_WIDTH-1:0] emit_dat;
    logic [DATA_MOD_WIDTH-1:0] emit_mod;

    // Arrival order k lands at bit DATA_BUS_WIDTH-1-k.
    assign pos = TOP_POS - cnt[DATA_MOD_WIDTH-1:0];

    always_comb begin
        state_n  = state;
        sh_n     = sh;
        cnt_n    = cnt;
        emit     = 1'b0;
        emit_dat = sh;
        emit_mod = '0;
        case (state)
            IDLE: begin
                if (ser_data_val_i) begin
                    sh_n                   = '0;
                    sh_n[DATA_BUS_WIDTH-1] = ser_data_i;
                    cnt_n                  = (DATA_MOD_WIDTH+1)'(1);
                    state_n                = COLLECT;
                end
            end
            COLLECT: begin
                if (ser_data_val_i) begin
                    sh_n[pos] = ser_data_i;
                    if (cnt == LAST_CNT) begin
                        emit     = 1'b1;
                        emit_dat = sh_n;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    emit     = 1'b1;
                    emit_mod = cnt[DATA_MOD_WIDTH-1:0];
                    cnt_n    = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            sh               <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state            <= state_n;
            sh               <= sh_n;
            cnt              <= cnt_n;
            deser_data_val_o <= emit;
            busy_o           <= (cnt_n != '0);
            // Data and mod hold their last emitted values between pulses.
            if (emit) begin
                deser_data_o     <= emit_dat;
                deser_data_mod_o <= emit_mod;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_top.sv
// Directed bench for deserializer_top with a cycle-by-cycle reference model of the receive framing.
module tb_deserializer_top;
    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ser = 1'b0;
    logic          ser_val = 1'b0;
    logic [W-1:0]  dat;
    logic [MW-1:0] mod;
    logic          val;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [W-1:0]  m_sh  = '0;
    logic [W-1:0]  e_dat = '0;
    logic [MW-1:0] e_mod = '0;
    logic          e_val = 1'b0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    deserializer_top #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .ser_data_i       (ser),
        .ser_data_val_i   (ser_val),
        .deser_data_o     (dat),
        .deser_data_mod_o (mod),
        .deser_data_val_o (val),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic d);
        e_val = 1'b0;
        if (v) begin
            if (m_cnt == 0) m_sh = '0;
            m_sh[W-1-m_cnt] = d;
            m_cnt++;
            if (m_cnt == W) begin
                e_val = 1'b1;
                e_dat = m_sh;
                e_mod = '0;
                m_cnt = 0;
            end
        end else if (m_cnt != 0) begin
            e_val = 1'b1;
            e_dat = m_sh;
            e_mod = MW'(m_cnt);
            m_cnt = 0;
        end
    endtask

    task automatic step(input logic v, input logic d);
        ser_val = v;
        ser     = v ? d : 1'($urandom_range(0, 1));
        model(v, d);
        @(posedge clk);
        #1;
        if (val === 1'b1) pulses++;
        chk("val", 32'(val), 32'(e_val));
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("dat", 32'(dat), 32'(e_dat));
        chk("mod", 32'(mod), 32'(e_mod));
    endtask

    task automatic send(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[W-1-i]);
    endtask

    initial begin
        int p0;
        logic v;

        #12;
        chk("rst_dat", 32'(dat), 32'h0);
        chk("rst_mod", 32'(mod), 32'h0);
        chk("rst_val", 32'(val), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word, pulse on the 16th sampled bit.
        send(16'hA5C3, 16);
        chk("a5c3_dat", 32'(dat), 32'hA5C3);
        chk("a5c3_mod", 32'(mod), 32'h0);
        chk("a5c3_val", 32'(val), 32'h1);
        chk("a5c3_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b0);
        chk("a5c3_hold", 32'(dat), 32'hA5C3);
        chk("a5c3_fall", 32'(val), 32'h0);

        // Short word 1,0,1,1,0 terminated by one idle cycle.
        send(16'hB000, 5);
        chk("short_busy", 32'(busy), 32'h1);
        step(1'b0, 1'b0);
        chk("short_dat", 32'(dat), 32'hB000);
        chk("short_mod", 32'(mod), 32'h5);
        chk("short_val", 32'(val), 32'h1);
        step(1'b0, 1'b0);

        // Back-to-back full words.
        p0 = pulses;
        send(16'h1234, 16);
        chk("b2b0_dat", 32'(dat), 32'h1234);
        send(16'hFFFF, 16);
        chk("b2b1_dat", 32'(dat), 32'hFFFF);
        chk("b2b1_mod", 32'(mod), 32'h0);
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);
        step(1'b0, 1'b0);

        // One-bit word, then a 15-bit word.
        send(16'h8000, 1);
        step(1'b0, 1'b0);
        chk("one_dat", 32'(dat), 32'h8000);
        chk("one_mod", 32'(mod), 32'h1);
        send(16'hFFFE, 15);
        step(1'b0, 1'b0);
        chk("fifteen_dat", 32'(dat), 32'hFFFE);
        chk("fifteen_mod", 32'(mod), 32'hF);
        chk("fifteen_bit0", 32'(dat[0]), 32'h0);

        // Asynchronous reset mid-word discards the partial word.
        send(16'hABCD, 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_val", 32'(val), 32'h0);
        chk("arst_dat", 32'(dat), 32'h0);
        chk("arst_mod", 32'(mod), 32'h0);
        m_cnt = 0;
        m_sh  = '0;
        e_dat = '0;
        e_mod = '0;
        e_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        send(16'h0F0F, 16);
        chk("post_rst_dat", 32'(dat), 32'h0F0F);
        chk("post_rst_mod", 32'(mod), 32'h0);
        chk("post_rst_pulses", 32'(pulses - p0), 32'd1);
        step(1'b0, 1'b0);

        // Random valid/idle pattern against the model.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
